clock_switch_ctrl: RTL
======================

CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 Parameter OFF_CYCLES, default 2, cycles the outgoing clock gate is held off before the select changes; range 1..255.
REQ-002 Parameter SEL_CYCLES, default 2, cycles the select is held stable with both gates off; range 1..255.
REQ-003 Parameter ON_CYCLES, default 2, cycles after the incoming gate enables before completion; range 1..255.
REQ-004 clk_i  input  1  controller clock (always-on reference); single clock domain.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 req_i  input  1  switch request, level; accepted when req_i && ready_o.
REQ-007 sel_target_i  input  1  requested source (0 = clk0, 1 = clk1), sampled on acceptance only.
REQ-008 ready_o  output  1  high only in IDLE.
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 clk_sel_o  output  1  select for the downstream 2:1 clock mux.
REQ-011 clk0_en_o / clk1_en_o  output  1 each  enables for the clock gates on clk0 / clk1 ahead of the mux.

Function
REQ-012 All outputs shall be registered; no combinational path from an input to any output.
REQ-013 FSM states shall be IDLE, GATE_OFF, SWITCH, GATE_ON, DONE.
REQ-014 IDLE: on acceptance with sel_target_i != clk_sel_o -> GATE_OFF; with sel_target_i == clk_sel_o -> DONE (no gate/select change).
REQ-015 GATE_OFF: the currently selected gate enable shall deassert on entry and the state shall last exactly OFF_CYCLES cycles -> SWITCH.
REQ-016 SWITCH: clk_sel_o shall take the latched target on entry and the state shall last exactly SEL_CYCLES cycles -> GATE_ON.
REQ-017 GATE_ON: the newly selected gate enable shall assert on entry and the state shall last exactly ON_CYCLES cycles -> DONE.
REQ-018 DONE: ack_o = 1 for exactly one cycle -> IDLE.
REQ-019 Acceptance at cycle t (differing target) shall give: old enable low at t+1, clk_sel_o toggled at t+1+OFF_CYCLES, new enable high at t+1+OFF_CYCLES+SEL_CYCLES, ack_o at t+1+OFF_CYCLES+SEL_CYCLES+ON_CYCLES, ready_o at the cycle after ack_o.
REQ-020 Same-target acceptance at t shall give ack_o at t+1 and ready_o at t+2 with outputs unchanged.
REQ-021 req_i and sel_target_i shall be ignored outside IDLE; changes of sel_target_i mid-sequence shall have no effect.
REQ-022 req_i held high through ack_o shall be re-accepted in the next IDLE cycle (back-to-back requests allowed).
REQ-023 Invariants: clk0_en_o and clk1_en_o never both high; clk_sel_o changes only while both enables are low; outside a sequence exactly the enable matching clk_sel_o is high.
REQ-024 Phase counter width shall be 8 bits; it reloads on each state entry and never wraps.

Reset
REQ-025 On rst_ni low, asynchronously: state IDLE, clk_sel_o = 0, clk0_en_o = 1, clk1_en_o = 0, ack_o = 0, ready_o = 1 after release, counter = 0.
REQ-026 Reset asserted mid-sequence shall abort immediately to the REQ-025 values; no ack_o for the aborted request.

Structure
REQ-027 Package clock_switch_pkg shall hold the state enum type, counter width constant (8) and default cycle constants.
REQ-028 No sub-module; the FSM and phase counter shall be in one module; the clock mux and clock gates are instantiated by the parent.

Verification
REQ-029 Reset, then req_i=1, sel_target_i=1 at t (defaults) -> clk0_en_o=0 at t+1, clk_sel_o=1 at t+3, clk1_en_o=1 at t+5, ack_o=1 at t+7 only, ready_o=1 at t+8.
REQ-030 From sel=1, request sel_target_i=1 -> ack_o at t+1, no change on clk_sel_o/enables, ready_o at t+2.
REQ-031 Toggle sel_target_i and pulse req_i during GATE_OFF/SWITCH -> sequence and timing identical to REQ-029; single ack_o.
REQ-032 rst_ni low at t+4 of a 0->1 switch -> same-cycle clk_sel_o=0, clk0_en_o=1, clk1_en_o=0; no ack_o.
REQ-033 req_i held high with sel_target_i alternating each accept, OFF=SEL=ON=1 -> back-to-back switches, ack_o every 5 cycles, invariants REQ-023 asserted every cycle.

Source files
------------

// File: rtl/clock_switch_pkg.sv
// Shared definitions for the glitch-free clock switch controller.
// Contents:
//   CntWidth         - width of the per-phase cycle counter
//   Def*Cycles       - default phase lengths in controller clock cycles
//   state_e          - controller FSM state type
package clock_switch_pkg;

    localparam int unsigned CntWidth     = 8;
    localparam int unsigned DefOffCycles = 2;
    localparam int unsigned DefSelCycles = 2;
    localparam int unsigned DefOnCycles  = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGateOff = 3'd1,
        StSwitch  = 3'd2,
        StGateOn  = 3'd3,
        StDone    = 3'd4
    } state_e;

endpackage

// File: rtl/clock_switch_ctrl.sv
// Sequencer for a glitch-free 2:1 clock switch. The parent owns the clock gates
// and the mux; this block only drives their controls, in the order
// gate old clock off -> move select -> gate new clock on -> acknowledge.
// Ports:
//   clk_i        always-on controller clock
//   rst_ni       asynchronous active-low reset
//   req_i        switch request (level), taken when req_i && ready_o
//   sel_target_i requested source, sampled only on acceptance
//   ready_o      high while idle
//   ack_o        one-cycle completion pulse
//   clk_sel_o    downstream mux select
//   clk0_en_o    gate enable for clk0
//   clk1_en_o    gate enable for clk1
module clock_switch_ctrl
    import clock_switch_pkg::*;
#(
    parameter int unsigned OFF_CYCLES = DefOffCycles,
    parameter int unsigned SEL_CYCLES = DefSelCycles,
    parameter int unsigned ON_CYCLES  = DefOnCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic sel_target_i,
    output logic ready_o,
    output logic ack_o,
    output logic clk_sel_o,
    output logic clk0_en_o,
    output logic clk1_en_o
);

    // Each phase counter loads length-1 on entry and leaves the phase at zero.
    localparam logic [CntWidth-1:0] OffLoad = CntWidth'(OFF_CYCLES - 1);
    localparam logic [CntWidth-1:0] SelLoad = CntWidth'(SEL_CYCLES - 1);
    localparam logic [CntWidth-1:0] OnLoad  = CntWidth'(ON_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                tgt_q, tgt_d;
    logic                sel_q, sel_d;
    logic                en0_q, en0_d;
    logic                en1_q, en1_d;
    logic                ack_q, ack_d;
    logic                ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        en0_d   = en0_q;
        en1_d   = en1_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (sel_target_i != sel_q) begin
                        state_d = StGateOff;
                        cnt_d   = OffLoad;
                        tgt_d   = sel_target_i;
                        // Drop only the gate of the clock currently feeding the mux.
                        if (sel_q) begin
                            en1_d = 1'b0;
                        end else begin
                            en0_d = 1'b0;
                        end
                    end else begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end
                end
            end
            StGateOff: begin
                if (cnt_q == '0) begin
                    state_d = StSwitch;
                    cnt_d   = SelLoad;
                    sel_d   = tgt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSwitch: begin
                if (cnt_q == '0) begin
                    state_d = StGateOn;
                    cnt_d   = OnLoad;
                    en0_d   = ~sel_q;
                    en1_d   = sel_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGateOn: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Registered flags derived from the next state keep the outputs glitch-free.
        ack_d   = (state_d == StDone);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            sel_q   <= 1'b0;
            en0_q   <= 1'b1;
            en1_q   <= 1'b0;
            ack_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            en0_q   <= en0_d;
            en1_q   <= en1_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o   = ready_q;
    assign ack_o     = ack_q;
    assign clk_sel_o = sel_q;
    assign clk0_en_o = en0_q;
    assign clk1_en_o = en1_q;

endmodule
